fp_trace_packer: RTL

Synthesizable trace writer for the single-precision FPU. It captures every operation issued to `fp_unit` together with its completion (result, flags). It emits one 156-bit record per operation in exactly the `fpu.dat` vector layout, so captured hardware traces replay through the existing vector-driven bench unchanged. It sits beside `fp_unit` and snoops the `fp_exe_i` and `fp_exe_o` fields. It never back-pressures the FPU.

---
 rtl/fp_wire_pkg.sv | 72 +++++++
 rtl/fp_trace_fifo.sv | 66 ++++++
 rtl/fp_trace_packer.sv | 149 ++++++++++++++
 3 files changed

// File: rtl/fp_wire_pkg.sv
// -----------------------------------------------------------------------------
// fp_wire: shared definitions for the FPU trace path.
//   - Opcode bit indices of the one-hot fp_unit opcode vector.
//   - fp_trace_rec_type: the 156-bit packed record, laid out bit-for-bit like a
//     line of the fpu.dat vector file (MSB first), including its zero pads.
//   - fp_trace_pend_type: the issue-side fields that wait for a completion.
//   - fp_trace_make_rec: builds a record from a pending entry and a completion.
// -----------------------------------------------------------------------------
package fp_wire;

  // One-hot opcode bit positions
  localparam int FP_OP_FMADD    = 0;
  localparam int FP_OP_FADD     = 1;
  localparam int FP_OP_FSUB     = 2;
  localparam int FP_OP_FMUL     = 3;
  localparam int FP_OP_FDIV     = 4;
  localparam int FP_OP_FSQRT    = 5;
  localparam int FP_OP_FCMP     = 6;
  localparam int FP_OP_RESERVED = 7;
  localparam int FP_OP_FCVT_I2F = 8;
  localparam int FP_OP_FCVT_F2I = 9;
  localparam int FP_OPCODE_W    = 10;

  // Record layout, MSB first
  typedef struct packed {
    logic [31:0]            data1;     // [155:124]
    logic [31:0]            data2;     // [123:92]
    logic [31:0]            data3;     // [91:60]
    logic [31:0]            result;    // [59:28]
    logic [2:0]             pad_flags; // [27:25]
    logic [4:0]             flags;     // [24:20]
    logic                   pad_rm;    // [19]
    logic [2:0]             rm;        // [18:16]
    logic [1:0]             pad_op;    // [15:14]
    logic [1:0]             op;        // [13:12]
    logic [1:0]             pad_opc;   // [11:10]
    logic [FP_OPCODE_W-1:0] opcode;    // [9:0]
  } fp_trace_rec_type;

  // Issue-side fields held until the matching completion arrives
  typedef struct packed {
    logic [31:0]            data1;
    logic [31:0]            data2;
    logic [31:0]            data3;
    logic [2:0]             rm;
    logic [1:0]             op;
    logic [FP_OPCODE_W-1:0] opcode;
  } fp_trace_pend_type;

  localparam int FP_TRACE_REC_W  = $bits(fp_trace_rec_type);
  localparam int FP_TRACE_PEND_W = $bits(fp_trace_pend_type);

  // Pads are forced to zero so replayed vectors compare cleanly.
  function automatic fp_trace_rec_type fp_trace_make_rec(
    input fp_trace_pend_type pend,
    input logic [31:0]       result,
    input logic [4:0]        flags
  );
    fp_trace_rec_type rec;
    rec           = '0;
    rec.data1     = pend.data1;
    rec.data2     = pend.data2;
    rec.data3     = pend.data3;
    rec.result    = result;
    rec.flags     = flags;
    rec.rm        = pend.rm;
    rec.op        = pend.op;
    rec.opcode    = pend.opcode;
    return rec;
  endfunction

endpackage

// File: rtl/fp_trace_fifo.sv
// -----------------------------------------------------------------------------
// fp_trace_fifo: plain synchronous FIFO with a combinational head view.
// The caller decides when push/pop are legal; no drop policy lives here.
// Pointers carry one extra wrap bit: full when the index bits match and the
// wrap bits differ, empty when the pointers are identical.
//
// Ports:
//   clock  in   rising-edge clock
//   reset  in   synchronous active-high reset (empties the FIFO)
//   push   in   write din at the tail (caller guarantees !full || pop)
//   pop    in   drop the head entry (caller guarantees !empty)
//   din    in   WIDTH-bit data to push
//   full   out  no free entry
//   empty  out  no stored entry
//   head   out  oldest entry (undefined content while empty)
// -----------------------------------------------------------------------------
module fp_trace_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic             full,
  output logic             empty,
  output logic [WIDTH-1:0] head
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = (AW + 1)'(1);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
    end
  end

  // Storage is not reset; the pointers alone define validity. A push while
  // full-and-popping overwrites the slot that is leaving this same edge.
  always_ff @(posedge clock) begin
    if (push) mem[wr_ptr_q[AW-1:0]] <= din;
  end

  assign empty = (wr_ptr_q == rd_ptr_q);
  assign full  = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) &&
                 (wr_ptr_q[AW] != rd_ptr_q[AW]);
  assign head  = mem[rd_ptr_q[AW-1:0]];

endmodule

// File: rtl/fp_trace_packer.sv
// -----------------------------------------------------------------------------
// fp_trace_packer: snoops fp_unit issue/completion traffic and emits one
// fpu.dat-format record per operation. Never stalls the FPU: when a FIFO has
// no room, the event is lost and reported (sticky flag or drop counter).
//
// Ports:
//   clock, reset                 rising-edge clock, synchronous active-high reset
//   iss_valid                    op issued this cycle
//   iss_data1/2/3, iss_rm,
//   iss_op, iss_opcode           issue fields captured into the pending FIFO
//   cmp_ready                    op completed this cycle (pairs with oldest pending)
//   cmp_result, cmp_flags        completion fields
//   rec_valid/rec_ready/rec_data record stream (valid/ready, head held while stalled)
//   pend_overflow                sticky: an issue was lost, pending FIFO full
//   pend_underflow               sticky: completion arrived with nothing pending
//   drop_count                   saturating count of records lost to a full output FIFO
// -----------------------------------------------------------------------------
module fp_trace_packer
  import fp_wire::*;
#(
  parameter int PEND_DEPTH = 8,
  parameter int OUT_DEPTH  = 4,
  parameter int CNT_W      = 16
) (
  input  logic                      clock,
  input  logic                      reset,
  input  logic                      iss_valid,
  input  logic [31:0]               iss_data1,
  input  logic [31:0]               iss_data2,
  input  logic [31:0]               iss_data3,
  input  logic [2:0]                iss_rm,
  input  logic [1:0]                iss_op,
  input  logic [FP_OPCODE_W-1:0]    iss_opcode,
  input  logic                      cmp_ready,
  input  logic [31:0]               cmp_result,
  input  logic [4:0]                cmp_flags,
  output logic                      rec_valid,
  input  logic                      rec_ready,
  output logic [FP_TRACE_REC_W-1:0] rec_data,
  output logic                      pend_overflow,
  output logic                      pend_underflow,
  output logic [CNT_W-1:0]          drop_count
);

  // ---------------------------------------------------------------------------
  // Pending FIFO: issue fields waiting for their completion
  // ---------------------------------------------------------------------------
  fp_trace_pend_type pend_din;
  fp_trace_pend_type pend_head;
  logic              pend_push, pend_pop, pend_full, pend_empty;

  always_comb begin
    pend_din        = '0;
    pend_din.data1  = iss_data1;
    pend_din.data2  = iss_data2;
    pend_din.data3  = iss_data3;
    pend_din.rm     = iss_rm;
    pend_din.op     = iss_op;
    pend_din.opcode = iss_opcode;
  end

  // Emptiness is judged before this cycle's push: an op never completes in
  // its own issue cycle, so a same-cycle issue cannot satisfy a completion.
  assign pend_pop  = cmp_ready & ~pend_empty;
  // A full FIFO still accepts the issue if the head leaves on the same edge.
  assign pend_push = iss_valid & (~pend_full | pend_pop);

  fp_trace_fifo #(
    .WIDTH (FP_TRACE_PEND_W),
    .DEPTH (PEND_DEPTH)
  ) u_pend_fifo (
    .clock (clock),
    .reset (reset),
    .push  (pend_push),
    .pop   (pend_pop),
    .din   (pend_din),
    .full  (pend_full),
    .empty (pend_empty),
    .head  (pend_head)
  );

  // ---------------------------------------------------------------------------
  // Output FIFO: completed records awaiting the consumer
  // ---------------------------------------------------------------------------
  fp_trace_rec_type out_din;
  fp_trace_rec_type out_head;
  logic             out_push, out_pop, out_full, out_empty;

  assign out_din  = fp_trace_make_rec(pend_head, cmp_result, cmp_flags);
  assign out_pop  = ~out_empty & rec_ready;
  assign out_push = pend_pop & (~out_full | out_pop);

  fp_trace_fifo #(
    .WIDTH (FP_TRACE_REC_W),
    .DEPTH (OUT_DEPTH)
  ) u_out_fifo (
    .clock (clock),
    .reset (reset),
    .push  (out_push),
    .pop   (out_pop),
    .din   (out_din),
    .full  (out_full),
    .empty (out_empty),
    .head  (out_head)
  );

  assign rec_valid = ~out_empty;
  // Storage is not reset, so mask the head to keep rec_data at zero when idle.
  assign rec_data  = out_empty ? '0 : out_head;

  // ---------------------------------------------------------------------------
  // Loss reporting
  // ---------------------------------------------------------------------------
  logic             pend_overflow_q, pend_overflow_d;
  logic             pend_underflow_q, pend_underflow_d;
  logic [CNT_W-1:0] drop_count_q, drop_count_d;
  logic             issue_lost, cmp_orphan, rec_lost;

  assign issue_lost = iss_valid & ~pend_push;
  assign cmp_orphan = cmp_ready & pend_empty;
  // The pending entry is consumed even when its record has nowhere to go.
  assign rec_lost   = pend_pop & ~out_push;

  always_comb begin
    pend_overflow_d  = pend_overflow_q | issue_lost;
    pend_underflow_d = pend_underflow_q | cmp_orphan;
    drop_count_d     = drop_count_q;
    if (rec_lost && (drop_count_q != {CNT_W{1'b1}})) begin
      drop_count_d = drop_count_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pend_overflow_q  <= 1'b0;
      pend_underflow_q <= 1'b0;
      drop_count_q     <= '0;
    end else begin
      pend_overflow_q  <= pend_overflow_d;
      pend_underflow_q <= pend_underflow_d;
      drop_count_q     <= drop_count_d;
    end
  end

  assign pend_overflow  = pend_overflow_q;
  assign pend_underflow = pend_underflow_q;
  assign drop_count     = drop_count_q;

endmodule
